mem_wait_responder: RTL and testbench

- Main-memory side of the cache/memory handshake: responds to MStrobe/MRW requests issued by the cache controller.
- Models a word-addressed backing store with a programmable wait-state latency, then returns a one-cycle MReady completion.
- Sits between the cache controller's memory port and the simulation/FPGA memory array.
- Replaces the controller-local wait counter as the source of memory timing.

---
 rtl/mem_wait_responder.sv | 121 ++++++++++++
 tb/tb_mem_wait_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_responder.sv
// Purpose : main-memory responder for the cache controller's MStrobe/MRW handshake,
//           backed by a word-addressed array with a fixed wait-state latency.
// Latency : MStrobe in cycle 0 -> MReady pulse in cycle WAIT_CYCLES+2; one request in flight.
// Backpressure: MBusy high while waiting; strobes seen then are dropped and flagged on MErr.
//
// Ports:
//   clk     - system clock, all state updates on the rising edge
//   reset   - asynchronous active-low reset (array contents are not cleared)
//   MStrobe - request strobe, accepted only in IDLE or DONE
//   MRW     - 1 = write, 0 = read, sampled with MStrobe
//   MAddr   - word address, sampled with MStrobe
//   MWData  - write data, sampled with MStrobe
//   MRData  - read data, valid with MReady, held until the next read completes
//   MReady  - one-cycle completion pulse for reads and writes
//   MBusy   - high while an accepted request is waiting
//   MErr    - one-cycle pulse in the cycle after a strobe arrived while busy
module mem_wait_responder #(
  parameter int AW          = 10,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MStrobe,
  input  logic          MRW,
  input  logic [AW-1:0] MAddr,
  input  logic [DW-1:0] MWData,
  output logic [DW-1:0] MRData,
  output logic          MReady,
  output logic          MBusy,
  output logic          MErr
);

  localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [7:0]    cnt_q;
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          ready_q;
  logic          busy_q;
  logic          err_q;

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic          mem_we;

  // The array commits on the same edge that leaves WAIT. Reset forces IDLE,
  // so an aborted write can never reach the array.
  assign mem_we = (state_q == S_WAIT) && (cnt_q == 8'd0) && rw_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        // DONE accepts a new strobe exactly like IDLE, giving back-to-back service.
        S_IDLE, S_DONE: begin
          if (MStrobe) begin
            rw_q    <= MRW;
            addr_q  <= MAddr;
            wdata_q <= MWData;
            cnt_q   <= WAIT_LD;
            state_q <= S_WAIT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          // A strobe here is dropped; the captured request is left untouched.
          err_q <= MStrobe;
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            if (!rw_q) begin
              rdata_q <= mem_q[addr_q];
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MRData = rdata_q;
  assign MReady = ready_q;
  assign MBusy  = busy_q;
  assign MErr   = err_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Purpose : self-checking bench for mem_wait_responder (WAIT_CYCLES=4 and WAIT_CYCLES=0 builds).
// Latency : inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: every wait for MReady is bounded by a cycle budget.
module tb_mem_wait_responder;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s, rw;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic [DW-1:0] rd;
  logic          rdy, bsy, err;
  logic          zs, zrw;
  logic [AW-1:0] za;
  logic [DW-1:0] zd;
  logic [DW-1:0] zrd;
  logic          zrdy, zbsy, zerr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wait_responder #(.AW(AW), .DW(DW), .WAIT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MStrobe(s), .MRW(rw), .MAddr(a), .MWData(d),
    .MRData(rd), .MReady(rdy), .MBusy(bsy), .MErr(err)
  );

  mem_wait_responder #(.AW(AW), .DW(DW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .MStrobe(zs), .MRW(zrw), .MAddr(za), .MWData(zd),
    .MRData(zrd), .MReady(zrdy), .MBusy(zbsy), .MErr(zerr)
  );

  typedef struct {
    logic          s;
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rdy;
    logic          bsy;
    logic          err;
    logic [DW-1:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic s_, input logic rw_, input logic [AW-1:0] a_,
                              input logic [DW-1:0] d_, input logic r_, input logic b_,
                              input logic e_, input logic [DW-1:0] rd_);
    vec_t v;
    v.s = s_; v.rw = rw_; v.a = a_; v.d = d_;
    v.rdy = r_; v.bsy = b_; v.err = e_; v.rd = rd_;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int c, input logic er, input logic eb,
                         input logic ee);
    chk({tag, ".MReady"}, c, {31'b0, rdy}, {31'b0, er});
    chk({tag, ".MBusy"},  c, {31'b0, bsy}, {31'b0, eb});
    chk({tag, ".MErr"},   c, {31'b0, err}, {31'b0, ee});
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s_, input logic rw_, input logic [AW-1:0] a_,
                       input logic [DW-1:0] d_);
    s = s_; rw = rw_; a = a_; d = d_;
  endtask

  // One complete transaction on the WAIT_CYCLES=4 instance, starting from IDLE.
  task automatic do_txn(input logic rw_, input logic [AW-1:0] a_, input logic [DW-1:0] d_,
                        output logic [DW-1:0] r);
    logic got;
    got = 1'b0;
    r = '0;
    drive(1'b1, rw_, a_, d_);
    next();
    drive(1'b0, 1'b0, 10'h0, 32'h0);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rdy) begin
        got = 1'b1;
        r = rd;
      end
      next();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL txn_timeout addr %h: MReady not seen, required within 50 cycles", a_);
    end
  endtask

  vec_t t1 [15];
  logic [DW-1:0] r;

  initial begin
    drive(1'b0, 1'b0, 10'h0, 32'h0);
    zs = 1'b0; zrw = 1'b0; za = '0; zd = '0;

    // Reset state
    #3 reset = 1'b0;
    @(negedge clk);
    chk_out("reset", 0, 1'b0, 1'b0, 1'b0);
    chk("reset.MRData", 0, rd, 32'h0);
    chk("reset0.MRData", 0, zrd, 32'h0);
    chk("reset0.MReady", 0, {31'b0, zrdy}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Write then read 0x005, table-driven
    t1[0]  = mk(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0);
    t1[1]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
    t1[2]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
    t1[3]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
    t1[4]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
    t1[5]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
    t1[6]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0);
    t1[7]  = mk(1'b1, 1'b0, 10'h005, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0);
    t1[8]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
    t1[9]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
    t1[10] = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
    t1[11] = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
    t1[12] = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
    t1[13] = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    t1[14] = mk(1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    for (int c = 0; c < 15; c++) begin
      drive(t1[c].s, t1[c].rw, t1[c].a, t1[c].d);
      @(negedge clk);
      chk_out("wr_rd", c, t1[c].rdy, t1[c].bsy, t1[c].err);
      chk("wr_rd.MRData", c, rd, t1[c].rd);
      next();
    end

    // Preload locations used below
    do_txn(1'b1, 10'h001, 32'h11111111, r);
    do_txn(1'b1, 10'h002, 32'h22222222, r);
    do_txn(1'b1, 10'h020, 32'h20202020, r);
    do_txn(1'b1, 10'h030, 32'h30303030, r);
    chk("write_keeps.MRData", 0, rd, 32'hDEADBEEF);

    // Back-to-back reads with MStrobe held high for three transactions
    for (int c = 0; c < 19; c++) begin
      drive(c < 18, 1'b0, ((c / 6) % 2 == 0) ? 10'h001 : 10'h002, 32'h0);
      @(negedge clk);
      chk_out("b2b", c, (c > 0) && (c % 6 == 0), (c % 6 != 0), (c >= 2) && (c % 6 != 1));
      if (c > 0 && c % 6 == 0)
        chk("b2b.MRData", c, rd, ((c / 6) % 2 == 1) ? 32'h11111111 : 32'h22222222);
      next();
    end
    drive(1'b0, 1'b0, 10'h0, 32'h0);
    next();

    // Busy collision: read strobe in cycle 3 is dropped
    for (int c = 0; c < 9; c++) begin
      if (c == 0)      drive(1'b1, 1'b1, 10'h010, 32'h10101010);
      else if (c == 3) drive(1'b1, 1'b0, 10'h020, 32'h0);
      else             drive(1'b0, 1'b0, 10'h000, 32'h0);
      @(negedge clk);
      chk_out("busy", c, c == 6, (c >= 1) && (c <= 5), c == 4);
      next();
    end
    do_txn(1'b0, 10'h020, 32'h0, r);
    chk("busy.arr020", 0, r, 32'h20202020);
    do_txn(1'b0, 10'h010, 32'h0, r);
    chk("busy.arr010", 0, r, 32'h10101010);

    // Reset in the middle of a write
    drive(1'b1, 1'b1, 10'h030, 32'hCAFEF00D);
    next();
    drive(1'b0, 1'b0, 10'h000, 32'h0);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      chk("rstmid.MBusy_pre", c, {31'b0, bsy}, 32'h1);
      next();
    end
    reset = 1'b0;
    #1;
    chk("rstmid.MBusy_async", 3, {31'b0, bsy}, 32'h0);
    chk("rstmid.MRData_async", 3, rd, 32'h0);
    next();
    reset = 1'b1;
    for (int c = 4; c < 12; c++) begin
      @(negedge clk);
      chk_out("rstmid", c, 1'b0, 1'b0, 1'b0);
      next();
    end
    do_txn(1'b0, 10'h030, 32'h0, r);
    chk("rstmid.arr030", 0, r, 32'h30303030);

    // WAIT_CYCLES=0 instance: write then back-to-back read of the top address
    for (int c = 0; c < 6; c++) begin
      zs = (c == 0) || (c == 2);
      zrw = (c == 0);
      za = 10'h3FF;
      zd = (c == 0) ? 32'h0000ABCD : 32'h0;
      @(negedge clk);
      chk("w0.MReady", c, {31'b0, zrdy}, {31'b0, (c == 2) || (c == 4)});
      chk("w0.MBusy",  c, {31'b0, zbsy}, {31'b0, (c == 1) || (c == 3)});
      chk("w0.MErr",   c, {31'b0, zerr}, 32'h0);
      chk("w0.MRData", c, zrd, (c >= 4) ? 32'h0000ABCD : 32'h0);
      next();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
